// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Scoreboard-based operand forwarding selects plus load-use and
//               memory-wait stall control for a 5-stage in-order pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_valid,
    input  logic [A-1:0] id_rs1,
    input  logic [A-1:0] id_rs2,
    input  logic [A-1:0] id_rd,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         mem_busy,
    input  logic         flush,
    output logic [1:0]   fwd_a_sel,
    output logic [1:0]   fwd_b_sel,
    output logic         stall_if,
    output logic         stall_id,
    output logic         bubble_ex
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic         valid;
        logic [A-1:0] rd;
        logic         reg_write;
        logic         mem_read;
    } sb_entry_t;

    localparam logic [1:0] C_SEL_RF  = 2'b00;
    localparam logic [1:0] C_SEL_EX  = 2'b01;
    localparam logic [1:0] C_SEL_MEM = 2'b10;

    state_t    state_q, state_d;
    state_t    ret_q, ret_d;
    logic      flush_pend_q, flush_pend_d;
    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    state_t w_eff_state;
    logic   w_flush;
    logic   w_load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [A-1:0] rs,
        input sb_entry_t    ex_e,
        input sb_entry_t    mem_e
    );
        logic [1:0] sel;
        sel = C_SEL_RF;
        if (rs != '0) begin
            if (ex_e.valid && ex_e.reg_write && (ex_e.rd == rs)) begin
                sel = C_SEL_EX;
            end else if (mem_e.valid && mem_e.reg_write && (mem_e.rd == rs)) begin
                sel = C_SEL_MEM;
            end
        end
        return sel;
    endfunction

    // A non-busy cycle in MEM_WAIT behaves exactly as the state that was interrupted.
    assign w_eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;
    assign w_flush     = flush | flush_pend_q;
    assign w_load_use  = id_valid && (w_eff_state != LOAD_STALL) &&
                         ex_q.valid && ex_q.mem_read &&
                         (((id_rs1 != '0) && (ex_q.rd == id_rs1)) ||
                          ((id_rs2 != '0) && (ex_q.rd == id_rs2)));

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        flush_pend_d = flush_pend_q;
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        bubble_ex    = 1'b0;

        if (!rst) begin
            if (mem_busy) begin
                stall_if     = 1'b1;
                stall_id     = 1'b1;
                state_d      = MEM_WAIT;
                flush_pend_d = flush_pend_q | flush;
                if (state_q != MEM_WAIT) begin
                    ret_d = state_q;
                end
            end else begin
                wb_d         = mem_q;
                mem_d        = ex_q;
                flush_pend_d = 1'b0;
                if (w_flush) begin
                    ex_d    = '0;
                    fwd_a_d = C_SEL_RF;
                    fwd_b_d = C_SEL_RF;
                    state_d = RUN;
                end else if (w_load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    ex_d      = '0;
                    fwd_a_d   = C_SEL_RF;
                    fwd_b_d   = C_SEL_RF;
                    state_d   = LOAD_STALL;
                end else begin
                    ex_d.valid     = id_valid;
                    ex_d.rd        = id_rd;
                    ex_d.reg_write = id_reg_write;
                    ex_d.mem_read  = id_mem_read;
                    fwd_a_d        = id_valid ? fwd_sel(id_rs1, ex_q, mem_q) : C_SEL_RF;
                    fwd_b_d        = id_valid ? fwd_sel(id_rs2, ex_q, mem_q) : C_SEL_RF;
                    state_d        = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            ret_q        <= RUN;
            flush_pend_q <= 1'b0;
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            fwd_a_q      <= C_SEL_RF;
            fwd_b_q      <= C_SEL_RF;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            flush_pend_q <= flush_pend_d;
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

endmodule
`default_nettype wire
